// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: queues conv job descriptors and launches them one at a time on the accelerator
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   job_*                 host job queue write port (valid/ready, image/kernal/conv addresses)
//   acc_*                 accelerator command (start, addresses) and status (offset, busy, done)
//   res_*                 result record to host (valid/ready, offset, elapsed cycles, timeout flag)
//   seq_busy              a job is in flight or queued
module conv_job_sequencer #(
    parameter int ADDR_WIDTH     = 15,
    parameter int OFFSET_WIDTH   = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CYCLE_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [ADDR_WIDTH-1:0]   job_addr_image,
    input  logic [ADDR_WIDTH-1:0]   job_addr_kernal,
    input  logic [ADDR_WIDTH-1:0]   job_addr_conv,
    output logic                    acc_start,
    output logic [ADDR_WIDTH-1:0]   acc_addr_image,
    output logic [ADDR_WIDTH-1:0]   acc_addr_kernal,
    output logic [ADDR_WIDTH-1:0]   acc_addr_conv,
    input  logic [OFFSET_WIDTH-1:0] acc_offset,
    input  logic                    acc_busy,
    input  logic                    acc_done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OFFSET_WIDTH-1:0] res_offset,
    output logic [CYCLE_WIDTH-1:0]  res_cycles,
    output logic                    res_timeout,
    output logic                    seq_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int JW = 3 * ADDR_WIDTH;
    localparam logic [CYCLE_WIDTH-1:0] START_LAST   = CYCLE_WIDTH'(START_CYCLES);
    localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_LAST = CYCLE_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [PW:0]            FULL_COUNT   = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, REPORT, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [JW-1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;
    logic [CYCLE_WIDTH-1:0] cycles;
    logic                   push, pop, done_hit, timeout_hit;

    assign job_ready   = count != FULL_COUNT;
    assign push        = job_valid && job_ready;
    assign pop         = state == IDLE && |count && !acc_busy;
    assign done_hit    = state == RUN && acc_done;
    // done in the timeout cycle takes priority
    assign timeout_hit = state == RUN && !acc_done && cycles >= TIMEOUT_LAST;
    // decoded from the async-reset state so start drops the moment reset rises
    assign acc_start   = state == LAUNCH;
    assign res_valid   = state == REPORT;
    assign seq_busy    = state != IDLE || |count;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pop ? LAUNCH : IDLE;
            // the cycle counter doubles as the start-pulse length counter
            LAUNCH:  state_nxt = cycles >= START_LAST ? RUN : LAUNCH;
            RUN:     state_nxt = done_hit || timeout_hit ? REPORT : RUN;
            REPORT:  state_nxt = !res_ready ? REPORT : res_timeout ? DRAIN : IDLE;
            DRAIN:   state_nxt = acc_busy ? DRAIN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {job_addr_image, job_addr_kernal, job_addr_conv};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            cycles          <= '0;
            acc_addr_image  <= '0;
            acc_addr_kernal <= '0;
            acc_addr_conv   <= '0;
            res_offset      <= '0;
            res_cycles      <= '0;
            res_timeout     <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                {acc_addr_image, acc_addr_kernal, acc_addr_conv} <= mem[rd_ptr];
            end
            if (pop) cycles <= CYCLE_WIDTH'(1);
            else if ((state == LAUNCH || state == RUN) && cycles != '1) cycles <= cycles + 1'b1;
            if (done_hit || timeout_hit) begin
                res_offset  <= done_hit ? acc_offset : '0;
                res_cycles  <= cycles;
                res_timeout <= timeout_hit;
            end
        end
    end
endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb_conv_job_sequencer: directed self-checking bench for conv_job_sequencer
module tb_conv_job_sequencer;
    localparam int AW  = 15;
    localparam int OW  = 16;
    localparam int CW  = 32;
    localparam int TMO = 120;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          job_valid, job_ready;
    logic [AW-1:0] job_addr_image, job_addr_kernal, job_addr_conv;
    logic          acc_start;
    logic [AW-1:0] acc_addr_image, acc_addr_kernal, acc_addr_conv;
    logic [OW-1:0] acc_offset;
    logic          acc_busy, acc_done;
    logic          res_valid, res_ready;
    logic [OW-1:0] res_offset;
    logic [CW-1:0] res_cycles;
    logic          res_timeout, seq_busy;

    int checks = 0;
    int failures = 0;

    conv_job_sequencer #(
        .ADDR_WIDTH(AW), .OFFSET_WIDTH(OW), .FIFO_DEPTH(4),
        .START_CYCLES(2), .TIMEOUT_CYCLES(TMO), .CYCLE_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_addr_image(job_addr_image), .job_addr_kernal(job_addr_kernal), .job_addr_conv(job_addr_conv),
        .acc_start(acc_start),
        .acc_addr_image(acc_addr_image), .acc_addr_kernal(acc_addr_kernal), .acc_addr_conv(acc_addr_conv),
        .acc_offset(acc_offset), .acc_busy(acc_busy), .acc_done(acc_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_offset(res_offset), .res_cycles(res_cycles), .res_timeout(res_timeout),
        .seq_busy(seq_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [AW-1:0] i, input logic [AW-1:0] k, input logic [AW-1:0] c);
        job_valid = 1'b1;
        job_addr_image = i;
        job_addr_kernal = k;
        job_addr_conv = c;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_start(input int maxc);
        int n = 0;
        while (!acc_start && n < maxc) begin
            tick();
            n++;
        end
        chk("start_seen", {63'd0, acc_start}, 64'd1);
    endtask

    function automatic logic [63:0] addrs();
        return {19'd0, acc_addr_image, acc_addr_kernal, acc_addr_conv};
    endfunction

    function automatic logic [63:0] pack(input logic [AW-1:0] i, input logic [AW-1:0] k, input logic [AW-1:0] c);
        return {19'd0, i, k, c};
    endfunction

    initial begin
        logic [AW-1:0] qi[5], qk[5], qc[5];
        int bad;
        job_valid = 1'b0;
        job_addr_image = '0;
        job_addr_kernal = '0;
        job_addr_conv = '0;
        acc_offset = '0;
        acc_busy = 1'b0;
        acc_done = 1'b0;
        res_ready = 1'b0;

        // reset state
        tick(2);
        chk("rst_start", {63'd0, acc_start}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_res_timeout", {63'd0, res_timeout}, 64'd0);
        chk("rst_seq_busy", {63'd0, seq_busy}, 64'd0);
        chk("rst_job_ready", {63'd0, job_ready}, 64'd1);
        chk("rst_addrs", addrs(), 64'd0);
        chk("rst_res_offset", {48'd0, res_offset}, 64'd0);
        chk("rst_res_cycles", {32'd0, res_cycles}, 64'd0);
        reset = 1'b0;
        tick();

        // single job
        push_job(15'h0000, 15'h4009, 15'h4000);
        chk("lat_t1_start", {63'd0, acc_start}, 64'd0);
        tick();
        chk("lat_t2_start", {63'd0, acc_start}, 64'd1);
        chk("single_addrs", addrs(), pack(15'h0000, 15'h4009, 15'h4000));
        acc_busy = 1'b1;
        tick();
        chk("start_cycle2", {63'd0, acc_start}, 64'd1);
        tick();
        chk("start_fell", {63'd0, acc_start}, 64'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc_start || res_valid || addrs() != pack(15'h0000, 15'h4009, 15'h4000)) bad++;
        end
        chk("run_hold", 64'(bad), 64'd0);
        acc_done = 1'b1;
        acc_offset = 16'h0123;
        acc_busy = 1'b0;
        tick();
        acc_done = 1'b0;
        acc_offset = 16'hFFFF;
        chk("single_res_valid", {63'd0, res_valid}, 64'd1);
        chk("single_res_offset", {48'd0, res_offset}, 64'h0123);
        chk("single_res_cycles", {32'd0, res_cycles}, 64'd103);
        chk("single_res_timeout", {63'd0, res_timeout}, 64'd0);

        // result backpressure for 20 cycles with a job enqueued meanwhile
        push_job(15'h1111, 15'h2222, 15'h3333);
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            if (!res_valid || res_offset != 16'h0123 || res_cycles != 32'd103 || res_timeout || acc_start) bad++;
            tick();
        end
        chk("bp_hold", 64'(bad), 64'd0);
        chk("bp_job_ready", {63'd0, job_ready}, 64'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("b2b_r1_valid", {63'd0, res_valid}, 64'd0);
        chk("b2b_r1_start", {63'd0, acc_start}, 64'd0);
        tick();
        chk("b2b_r2_start", {63'd0, acc_start}, 64'd1);
        chk("b2b_addrs", addrs(), pack(15'h1111, 15'h2222, 15'h3333));

        // done arriving in exactly the timeout cycle
        acc_busy = 1'b1;
        tick(TMO - 1);
        acc_done = 1'b1;
        acc_offset = 16'hBEEF;
        tick();
        acc_done = 1'b0;
        acc_busy = 1'b0;
        chk("coll_res_valid", {63'd0, res_valid}, 64'd1);
        chk("coll_res_timeout", {63'd0, res_timeout}, 64'd0);
        chk("coll_res_offset", {48'd0, res_offset}, 64'hBEEF);
        chk("coll_res_cycles", {32'd0, res_cycles}, 64'(TMO));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("coll_idle", {63'd0, seq_busy}, 64'd0);

        // timeout with busy stuck high, then drain
        push_job(15'h0A0A, 15'h0B0B, 15'h0C0C);
        wait_start(4);
        acc_busy = 1'b1;
        tick(TMO - 1);
        chk("tmo_not_early", {63'd0, res_valid}, 64'd0);
        tick();
        chk("tmo_res_valid", {63'd0, res_valid}, 64'd1);
        chk("tmo_res_timeout", {63'd0, res_timeout}, 64'd1);
        chk("tmo_res_offset", {48'd0, res_offset}, 64'd0);
        chk("tmo_res_cycles", {32'd0, res_cycles}, 64'(TMO));
        push_job(15'h0D0D, 15'h0E0E, 15'h0F0F);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (acc_start) bad++;
            tick();
        end
        chk("drain_no_start", 64'(bad), 64'd0);
        chk("drain_seq_busy", {63'd0, seq_busy}, 64'd1);
        acc_busy = 1'b0;
        tick();
        chk("drain_exit_start", {63'd0, acc_start}, 64'd0);
        tick();
        chk("after_drain_start", {63'd0, acc_start}, 64'd1);
        chk("after_drain_addrs", addrs(), pack(15'h0D0D, 15'h0E0E, 15'h0F0F));
        acc_busy = 1'b1;
        tick(5);
        acc_done = 1'b1;
        acc_offset = 16'h0042;
        tick();
        acc_done = 1'b0;
        acc_busy = 1'b0;
        chk("short_res_offset", {48'd0, res_offset}, 64'h0042);
        chk("short_res_cycles", {32'd0, res_cycles}, 64'd6);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // queue full: five pushes while the accelerator reports busy
        acc_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            qi[i] = AW'(16'h0100 + i);
            qk[i] = AW'(16'h0200 + i);
            qc[i] = AW'(16'h0300 + i);
            job_valid = 1'b1;
            job_addr_image = qi[i];
            job_addr_kernal = qk[i];
            job_addr_conv = qc[i];
            chk("full_ready", {63'd0, job_ready}, i < 4 ? 64'd1 : 64'd0);
            tick();
        end
        chk("full_ready_hold", {63'd0, job_ready}, 64'd0);
        job_valid = 1'b0;
        chk("full_no_start", {63'd0, acc_start}, 64'd0);
        acc_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_start(4);
            chk("fifo_order", addrs(), pack(qi[i], qk[i], qc[i]));
            if (i == 0) chk("ready_after_pop", {63'd0, job_ready}, 64'd1);
            acc_busy = 1'b1;
            tick(3);
            acc_done = 1'b1;
            acc_offset = OW'(i + 1);
            tick();
            acc_done = 1'b0;
            acc_busy = 1'b0;
            chk("fifo_res_offset", {48'd0, res_offset}, 64'(i + 1));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        tick(4);
        chk("no_fifth_busy", {63'd0, seq_busy}, 64'd0);
        chk("no_fifth_start", {63'd0, acc_start}, 64'd0);

        // reset during a launch with another job queued
        push_job(15'h7777, 15'h6666, 15'h5555);
        push_job(15'h1234, 15'h2345, 15'h3456);
        wait_start(4);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_start", {63'd0, acc_start}, 64'd0);
        chk("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("mid_rst_job_ready", {63'd0, job_ready}, 64'd1);
        chk("mid_rst_seq_busy", {63'd0, seq_busy}, 64'd0);
        chk("mid_rst_addrs", addrs(), 64'd0);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (acc_start || seq_busy) bad++;
        end
        chk("rst_flushed", 64'(bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
